// File: rtl/rx_frame_host.sv
// Receive framing stage: hunts for an 8-bit sync pattern in the recovered bit stream and
// assembles the next 16 bits into a host-visible word. Define RX_PARITY_EN to add a 17th even-parity bit.
module rx_frame_host #(
    parameter logic [7:0] SYNC_WORD       = 8'hD5,
    parameter int         CARRIER_TIMEOUT = 64
) (
    input  logic       G_CLK_RX,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       carrier_status,
    input  logic       rx_enable,
    input  logic       int_mask,
    input  logic       int_ack,
    output logic [7:0] data_byte_1,
    output logic [7:0] data_byte_0,
    output logic       int_flag,
    output logic       status_out,
    output logic       int_rx_host,
    output logic       overrun,
    output logic       parity_err,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUNT = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;

`ifdef RX_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif
    localparam logic [4:0] LAST_BIT  = 5'(NBITS - 1);
    localparam logic [7:0] TIMEOUT_C = 8'(CARRIER_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  window_q, window_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  loss_q, loss_d;
    logic        status_q, status_d;
    logic [7:0]  d1_q, d1_d;
    logic [7:0]  d0_q, d0_d;
    logic        int_flag_q, int_flag_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;
    logic        carrier_lost;
    logic        word_done;
    logic [15:0] word_val;
    logic [7:0]  window_next;
`ifdef RX_PARITY_EN
    logic        parity_bad;
    logic        parity_err_q, parity_err_d;
`endif

    assign window_next = {window_q[6:0], bit_in};

    always_comb begin
        // Loss counter saturates at the timeout so status stays low until carrier returns.
        loss_d = loss_q;
        if (carrier_status) begin
            loss_d = 8'd0;
        end else if (loss_q < TIMEOUT_C) begin
            loss_d = loss_q + 8'd1;
        end
        carrier_lost = (loss_d >= TIMEOUT_C);
        status_d     = ~carrier_lost;

        state_d   = state_q;
        window_d  = window_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        word_val  = 16'd0;
`ifdef RX_PARITY_EN
        parity_bad = 1'b0;
`endif

        if (!rx_enable) begin
            state_d  = ST_IDLE;
            window_d = 8'd0;
            shift_d  = 16'd0;
            cnt_d    = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_HUNT;
                    window_d = 8'd0;
                    shift_d  = 16'd0;
                    cnt_d    = 5'd0;
                end
                ST_HUNT: begin
                    if (bit_valid) begin
                        window_d = window_next;
                        if (window_next == SYNC_WORD) begin
                            state_d  = ST_RECV;
                            window_d = 8'd0;
                            shift_d  = 16'd0;
                            cnt_d    = 5'd0;
                        end
                    end
                end
                ST_RECV: begin
                    if (carrier_lost) begin
                        state_d  = ST_HUNT;
                        window_d = 8'd0;
                        shift_d  = 16'd0;
                        cnt_d    = 5'd0;
                    end else if (bit_valid) begin
                        cnt_d   = cnt_q + 5'd1;
                        shift_d = {shift_q[14:0], bit_in};
                        if (cnt_q == LAST_BIT) begin
                            state_d  = ST_HUNT;
                            window_d = 8'd0;
                            shift_d  = 16'd0;
                            cnt_d    = 5'd0;
`ifdef RX_PARITY_EN
                            // Final bit is even parity over the 16 data bits held in shift_q.
                            if (^{shift_q, bit_in}) begin
                                parity_bad = 1'b1;
                            end else begin
                                word_done = 1'b1;
                                word_val  = shift_q;
                            end
`else
                            word_done = 1'b1;
                            word_val  = {shift_q[14:0], bit_in};
`endif
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    window_d = 8'd0;
                    shift_d  = 16'd0;
                    cnt_d    = 5'd0;
                end
            endcase
        end

        d1_d       = d1_q;
        d0_d       = d0_q;
        int_flag_d = int_ack ? 1'b0 : int_flag_q;
        overrun_d  = int_ack ? 1'b0 : overrun_q;
        if (word_done) begin
            d1_d       = word_val[15:8];
            d0_d       = word_val[7:0];
            int_flag_d = 1'b1;
            if (int_flag_q && !int_ack) begin
                overrun_d = 1'b1;
            end
        end
        irq_d = int_flag_q & ~int_mask;

`ifdef RX_PARITY_EN
        parity_err_d = int_ack ? 1'b0 : parity_err_q;
        if (parity_bad) begin
            parity_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge G_CLK_RX or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            window_q   <= 8'd0;
            shift_q    <= 16'd0;
            cnt_q      <= 5'd0;
            loss_q     <= TIMEOUT_C;
            status_q   <= 1'b0;
            d1_q       <= 8'd0;
            d0_q       <= 8'd0;
            int_flag_q <= 1'b0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            loss_q     <= loss_d;
            status_q   <= status_d;
            d1_q       <= d1_d;
            d0_q       <= d0_d;
            int_flag_q <= int_flag_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge G_CLK_RX or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_byte_1 = d1_q;
    assign data_byte_0 = d0_q;
    assign int_flag    = int_flag_q;
    assign status_out  = status_q;
    assign int_rx_host = irq_q;
    assign overrun     = overrun_q;
    assign state_dbg   = state_q;

endmodule
